spinn_aer_pkt_builder: RTL and testbench

- AER-to-SpiNNaker direction: accepts address events from the sensor over a 4-phase asynchronous req/ack handshake.
- Forms SpiNNaker multicast packets using the virtual key and go signal supplied by the interface control stage.
- Presents packets on a vld/rdy packet interface to the SpiNNaker link transmitter.
- Buffers up to 2 packets; stalls the sensor (withholds ack) when full.

---
 rtl/spinn_aer_pkt_builder.sv | 149 ++++++++++++++
 tb/tb_spinn_aer_pkt_builder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spinn_aer_pkt_builder.sv
// AER (4-phase, async req/ack) to SpiNNaker multicast packet builder with a 2-entry FWFT packet FIFO.
// Latency: req fall to ack fall 3 clk, packet visible the same cycle; ack withheld while the FIFO is full.

module spinn_fifo #(
   parameter int W     = 72,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   output logic         wr_rdy,
   output logic         rd_vld,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          push, pop;

   assign wr_rdy = (count != (AW+1)'(DEPTH));
   assign rd_vld = (count != '0);
   assign rd_dat = mem[rd_ptr];
   assign push   = wr_vld && wr_rdy;
   assign pop    = rd_vld && rd_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

module spinn_aer_pkt_builder #(
   parameter int          AER_BITS  = 16,
   parameter logic [31:0] ADDR_MASK = 32'h0000_FFFF,
   parameter int          CNT_BITS  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                aer_req,
   input  logic [AER_BITS-1:0] aer_data,
   output logic                aer_ack,
   input  logic [31:0]         vkey,
   input  logic                go,
   output logic [71:0]         opkt_data,
   output logic                opkt_vld,
   input  logic                opkt_rdy,
   output logic [CNT_BITS-1:0] drop_cnt
);
   typedef enum logic {IDLE, ACK} state_t;

   state_t              state, state_nxt;
   logic                req_meta, req_s;
   logic [1:0]          sync_fill;
   logic                armed, armed_nxt;
   logic                ack_nxt;
   logic [CNT_BITS-1:0] drop_nxt;
   logic                capture;
   logic                fifo_wr_vld, fifo_wr_rdy;
   logic [31:0]         addr_ext, key;
   logic [7:0]          hdr;
   logic [71:0]         pkt;

   // sync_fill marks when req_s holds a real pin sample rather than its reset value,
   // so a request held low across reset can never arm the capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_meta  <= 1'b1;
         req_s     <= 1'b1;
         sync_fill <= 2'b00;
      end else begin
         req_meta  <= aer_req;
         req_s     <= req_meta;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   assign addr_ext = 32'(aer_data);
   assign key      = (vkey & ~ADDR_MASK) | (addr_ext & ADDR_MASK);
   assign hdr      = {7'b0, ~^key};
   assign pkt      = {32'b0, key, hdr};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         aer_ack  <= 1'b1;
         drop_cnt <= '0;
         armed    <= 1'b0;
      end else begin
         state    <= state_nxt;
         aer_ack  <= ack_nxt;
         drop_cnt <= drop_nxt;
         armed    <= armed_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ack_nxt   = aer_ack;
      drop_nxt  = drop_cnt;
      armed_nxt = armed | (req_s & sync_fill[1]);
      capture   = 1'b0;
      case (state)
         IDLE: begin
            ack_nxt = 1'b1;
            if (!req_s && armed && fifo_wr_rdy) begin
               capture   = 1'b1;
               state_nxt = ACK;
               ack_nxt   = 1'b0;
               armed_nxt = 1'b0;
               if (!go && (drop_cnt != '1)) drop_nxt = drop_cnt + CNT_BITS'(1);
            end
         end
         ACK: begin
            if (req_s) begin
               state_nxt = IDLE;
               ack_nxt   = 1'b1;
            end
         end
      endcase
   end

   assign fifo_wr_vld = capture & go;

   spinn_fifo #(.W(72), .DEPTH(2)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (fifo_wr_vld),
      .wr_dat (pkt),
      .wr_rdy (fifo_wr_rdy),
      .rd_vld (opkt_vld),
      .rd_rdy (opkt_rdy),
      .rd_dat (opkt_data)
   );
endmodule

// File: tb/tb_spinn_aer_pkt_builder.sv
// Bench for spinn_aer_pkt_builder: directed and random AER handshakes against a packet/drop-count model.
module tb_spinn_aer_pkt_builder;
   logic        clk = 1'b0;
   logic        rst;
   logic        aer_req;
   logic [15:0] aer_data;
   logic        aer_ack, aer_ack2;
   logic [31:0] vkey;
   logic        go;
   logic [71:0] opkt_data, opkt_data2;
   logic        opkt_vld, opkt_vld2;
   logic        opkt_rdy;
   logic [15:0] drop_cnt;
   logic [1:0]  drop_cnt2;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [71:0] got_q[$];
   logic [71:0] exp_q[$];
   int          drop_model;
   bit          rand_rdy;
   bit          hold_prev = 1'b0;
   logic [71:0] prev_dat;
   int          lat;

   always #5 clk = ~clk;

   spinn_aer_pkt_builder u_dut (
      .clk(clk), .rst(rst), .aer_req(aer_req), .aer_data(aer_data), .aer_ack(aer_ack),
      .vkey(vkey), .go(go), .opkt_data(opkt_data), .opkt_vld(opkt_vld),
      .opkt_rdy(opkt_rdy), .drop_cnt(drop_cnt)
   );

   spinn_aer_pkt_builder #(.CNT_BITS(2)) u_dut_sat (
      .clk(clk), .rst(rst), .aer_req(aer_req), .aer_data(aer_data), .aer_ack(aer_ack2),
      .vkey(vkey), .go(go), .opkt_data(opkt_data2), .opkt_vld(opkt_vld2),
      .opkt_rdy(opkt_rdy), .drop_cnt(drop_cnt2)
   );

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Packet per the key/header rules: low 16 key bits from the address, odd parity over {key,header}.
   function automatic logic [71:0] model_pkt(input logic [31:0] vk, input logic [15:0] d);
      logic [31:0] k;
      logic [7:0]  h;
      k = (vk & 32'hFFFF_0000) | {16'h0000, d};
      h = ($countones(k) % 2 == 0) ? 8'h01 : 8'h00;
      return {32'h0, k, h};
   endfunction

   // Observe away from the active edge: log accepted packets, check held packets stay put.
   always @(negedge clk) begin
      if (!rst) begin
         hold_prev <= 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_vld", 72'(opkt_vld), 72'(1));
            chk("hold_dat", opkt_data, prev_dat);
         end
         if (opkt_vld && opkt_rdy) got_q.push_back(opkt_data);
         hold_prev <= opkt_vld && !opkt_rdy;
         prev_dat  <= opkt_data;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rand_rdy) opkt_rdy = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic req_lo(input logic [15:0] d, input int max, output int l);
      aer_data = d;
      aer_req  = 1'b0;
      l = -1;
      for (int i = 1; i <= max; i++) begin
         cyc(1);
         if (aer_ack == 1'b0) begin l = i; break; end
      end
   endtask

   task automatic req_hi(input int max, output int l);
      aer_req = 1'b1;
      l = -1;
      for (int i = 1; i <= max; i++) begin
         cyc(1);
         if (aer_ack == 1'b1) begin l = i; break; end
      end
   endtask

   task automatic event_full(input logic [15:0] d, input logic g, input logic [31:0] vk);
      int l;
      go   = g;
      vkey = vk;
      req_lo(d, 200, l);
      chk("ev_ack_lo", 72'(l > 0), 72'(1));
      req_hi(200, l);
      chk("ev_ack_hi", 72'(l > 0), 72'(1));
      if (g) exp_q.push_back(model_pkt(vk, d));
      else   drop_model++;
   endtask

   task automatic drain();
      rand_rdy = 1'b0;
      opkt_rdy = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (!opkt_vld) break;
         cyc(1);
      end
      cyc(1);
      chk("drain_vld", 72'(opkt_vld), 72'(0));
   endtask

   task automatic cmp_queues(input string tag);
      int n;
      chk({tag, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, "_pkt"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b0; aer_req = 1'b1; aer_data = '0; vkey = '0; go = 1'b0;
      opkt_rdy = 1'b0; rand_rdy = 1'b0; drop_model = 0;
      cyc(2);
      chk("rst_ack", 72'(aer_ack), 72'(1));
      chk("rst_vld", 72'(opkt_vld), 72'(0));
      chk("rst_data", opkt_data, 72'(0));
      chk("rst_drop", 72'(drop_cnt), 72'(0));
      rst = 1'b1;
      cyc(3);

      // Basic event: ack falls 3 clk after req, key 1234_00A5 has nine 1s so parity bit is 0.
      go = 1'b1; vkey = 32'h1234_0000; opkt_rdy = 1'b1;
      req_lo(16'h00A5, 20, lat);
      chk("t1_ack_lat", 72'(lat), 72'(3));
      exp_q.push_back(model_pkt(32'h1234_0000, 16'h00A5));
      req_hi(20, lat);
      chk("t1_rel_lat", 72'(lat >= 2 && lat <= 3), 72'(1));
      drain();
      if (got_q.size() > 0) begin
         chk("t1_key", 72'(got_q[0][39:8]), 72'(32'h1234_00A5));
         chk("t1_hdr", 72'(got_q[0][7:0]), 72'(8'h00));
         chk("t1_payload", 72'(got_q[0][71:40]), 72'(0));
      end
      cmp_queues("t1");

      event_full(16'h0000, 1'b1, 32'hFFFF_FFFF);
      drain();
      if (got_q.size() > 0) begin
         chk("t2_key", 72'(got_q[0][39:8]), 72'(32'hFFFF_0000));
         chk("t2_hdr", 72'(got_q[0][7:0]), 72'(8'h01));
      end
      cmp_queues("t2");

      for (int i = 0; i < 5; i++) event_full(16'(i + 16), 1'b0, 32'hCAFE_0000);
      cyc(3);
      chk("t3_drop", 72'(drop_cnt), 72'(5));
      chk("t3_drop_sat", 72'(drop_cnt2), 72'(3));
      chk("t3_vld", 72'(opkt_vld), 72'(0));
      cmp_queues("t3");

      // Back-to-back with the sink stalled: third event must be held off.
      opkt_rdy = 1'b0;
      event_full(16'h0001, 1'b1, 32'hABCD_0000);
      event_full(16'h0002, 1'b1, 32'hABCD_0000);
      req_lo(16'h0003, 10, lat);
      chk("t4_stall_ack", 72'(aer_ack), 72'(1));
      chk("t4_stall_vld", 72'(opkt_vld), 72'(1));
      chk("t4_stall_got", 72'(got_q.size()), 72'(0));
      opkt_rdy = 1'b1;
      req_lo(16'h0003, 20, lat);
      chk("t4_ack3", 72'(lat > 0), 72'(1));
      exp_q.push_back(model_pkt(32'hABCD_0000, 16'h0003));
      req_hi(20, lat);
      drain();
      cmp_queues("t4");

      // go dropped after capture: event still delivered, no drop counted.
      go = 1'b1; vkey = 32'h5555_0000;
      req_lo(16'h0BEE, 20, lat);
      chk("t5_ack_lat", 72'(lat), 72'(3));
      go = 1'b0;
      req_hi(20, lat);
      exp_q.push_back(model_pkt(32'h5555_0000, 16'h0BEE));
      drain();
      cmp_queues("t5");
      chk("t5_drop", 72'(drop_cnt), 72'(drop_model));

      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++)
         event_full(16'($urandom), ($urandom_range(0, 3) != 0), $urandom);
      drain();
      cmp_queues("rnd");
      chk("rnd_drop", 72'(drop_cnt), 72'(drop_model));
      chk("rnd_drop_sat", 72'(drop_cnt2), 72'((drop_model > 3) ? 3 : drop_model));

      // Reset while in ACK with req held low: packet lost, no re-trigger.
      go = 1'b1; vkey = 32'h7777_0000; opkt_rdy = 1'b0;
      req_lo(16'h0055, 20, lat);
      chk("t7_ack_lat", 72'(lat), 72'(3));
      rst = 1'b0;
      #1;
      chk("t7_rst_ack", 72'(aer_ack), 72'(1));
      chk("t7_rst_vld", 72'(opkt_vld), 72'(0));
      chk("t7_rst_data", opkt_data, 72'(0));
      cyc(2);
      rst = 1'b1;
      drop_model = 0;
      cyc(10);
      chk("t7_held_ack", 72'(aer_ack), 72'(1));
      chk("t7_held_vld", 72'(opkt_vld), 72'(0));
      chk("t7_drop", 72'(drop_cnt), 72'(0));
      opkt_rdy = 1'b1;
      cyc(5);
      chk("t7_held_got", 72'(got_q.size()), 72'(0));
      aer_req = 1'b1;
      cyc(4);
      event_full(16'h0007, 1'b1, 32'h7777_0000);
      drain();
      if (got_q.size() > 0) chk("t7_key_lo", 72'(got_q[0][23:8]), 72'(16'h0007));
      cmp_queues("t7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
